// File: rtl/rob.sv
// Reorder buffer: in-order allocate/retire circular queue with CDB capture and operand lookup.
// Define ROB_BYPASS_EN to forward the live CDB broadcast into the operand lookup.
module rob #(
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic [DEPTH_LOG-1:0] alloc_tag,
  output logic                 rob_full,
  input  logic [DEPTH_LOG-1:0] qj_tag,
  input  logic [DEPTH_LOG-1:0] qk_tag,
  output logic                 qj_ok,
  output logic                 qk_ok,
  output logic [31:0]          vj,
  output logic [31:0]          vk,
  input  logic                 cdb_valid,
  input  logic [DEPTH_LOG-1:0] cdb_tag,
  input  logic [31:0]          cdb_val,
  input  logic                 cdb_mispredict,
  input  logic [31:0]          cdb_target,
  output logic                 commit_valid,
  output logic [DEPTH_LOG-1:0] commit_tag,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_val,
  output logic                 clear,
  output logic [31:0]          clear_pc
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_COUNT = {1'b1, {DEPTH_LOG{1'b0}}};

  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     ready;
  logic [DEPTH-1:0]     mispredict;
  logic [4:0]           rd_q     [DEPTH];
  logic [31:0]          val_q    [DEPTH];
  logic [31:0]          target_q [DEPTH];
  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] tail;
  logic [DEPTH_LOG:0]   count;

  logic do_commit;
  logic do_flush;
  logic do_issue;
  logic do_cdb;

  assign rob_full  = (count == FULL_COUNT);
  assign alloc_tag = tail;

  // A retiring mispredict squashes everything, including an issue in the same cycle.
  assign do_commit = rdy && (count != '0) && ready[head];
  assign do_flush  = do_commit && mispredict[head];
  assign do_issue  = rdy && issue_valid && !rob_full && !do_flush;
  assign do_cdb    = rdy && cdb_valid && busy[cdb_tag];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      ready        <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_rd    <= '0;
      commit_val   <= '0;
      clear        <= 1'b0;
      clear_pc     <= '0;
    end else begin
      commit_valid <= do_commit;
      clear        <= do_flush;
      if (do_cdb) begin
        ready[cdb_tag] <= 1'b1;
      end
      if (do_commit) begin
        commit_tag  <= head;
        commit_rd   <= rd_q[head];
        commit_val  <= val_q[head];
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (do_issue) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + 1'b1;
      end
      unique case ({do_issue, do_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (do_flush) begin
        clear_pc <= target_q[head];
        busy     <= '0;
        ready    <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end
    end
  end

  // Payload storage needs no reset; busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (do_issue) begin
      rd_q[tail]       <= issue_rd;
      mispredict[tail] <= 1'b0;
    end
    if (do_cdb) begin
      val_q[cdb_tag]      <= cdb_val;
      mispredict[cdb_tag] <= cdb_mispredict;
      target_q[cdb_tag]   <= cdb_target;
    end
  end

  always_comb begin
    qj_ok = busy[qj_tag] && ready[qj_tag];
    vj    = qj_ok ? val_q[qj_tag] : '0;
`ifdef ROB_BYPASS_EN
    if (cdb_valid && (cdb_tag == qj_tag) && busy[qj_tag]) begin
      qj_ok = 1'b1;
      vj    = cdb_val;
    end
`endif
  end

  always_comb begin
    qk_ok = busy[qk_tag] && ready[qk_tag];
    vk    = qk_ok ? val_q[qk_tag] : '0;
`ifdef ROB_BYPASS_EN
    if (cdb_valid && (cdb_tag == qk_tag) && busy[qk_tag]) begin
      qk_ok = 1'b1;
      vk    = cdb_val;
    end
`endif
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: a vector table for basic issue/complete/commit/lookup,
// plus hand-written sequences for fill/wrap, mispredict flush and mid-run reset.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  alloc_tag;
  logic        rob_full;
  logic [3:0]  qj_tag;
  logic [3:0]  qk_tag;
  logic        qj_ok;
  logic        qk_ok;
  logic [31:0] vj;
  logic [31:0] vk;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic        clear;
  logic [31:0] clear_pc;

  int vector_count = 0;
  int miscompares  = 0;

`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  rob dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alloc_tag(alloc_tag), .rob_full(rob_full),
    .qj_tag(qj_tag), .qk_tag(qk_tag),
    .qj_ok(qj_ok), .qk_ok(qk_ok), .vj(vj), .vk(vk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_val(commit_val),
    .clear(clear), .clear_pc(clear_pc)
  );

  typedef struct {
    logic        rst, rdy, iv;
    logic [4:0]  ird;
    logic [3:0]  qj, qk;
    logic        cv;
    logic [3:0]  ctag;
    logic [31:0] cval;
    logic        cmisp;
    logic [31:0] ctgt;
    logic [3:0]  x_alloc;
    logic        x_full, x_qjok;
    logic [31:0] x_vj;
    logic        x_qkok;
    logic [31:0] x_vk;
    logic        x_cv;
    logic [3:0]  x_ctag;
    logic [4:0]  x_crd;
    logic [31:0] x_cval;
    logic        x_clr;
    logic [31:0] x_clrpc;
  } vec_t;

  function automatic vec_t idle();
    vec_t v = '{default: 0};
    v.rdy = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then settle before sampling.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst            = v.rst;
    rdy            = v.rdy;
    issue_valid    = v.iv;
    issue_rd       = v.ird;
    qj_tag         = v.qj;
    qk_tag         = v.qk;
    cdb_valid      = v.cv;
    cdb_tag        = v.ctag;
    cdb_val        = v.cval;
    cdb_mispredict = v.cmisp;
    cdb_target     = v.ctgt;
    #2;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    vector_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input vec_t v, input logic chk_pay, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    checkField({s, " alloc_tag"}, 32'(alloc_tag), 32'(v.x_alloc));
    checkField({s, " rob_full"}, 32'(rob_full), 32'(v.x_full));
    checkField({s, " qj_ok"}, 32'(qj_ok), 32'(v.x_qjok));
    checkField({s, " vj"}, vj, v.x_vj);
    checkField({s, " qk_ok"}, 32'(qk_ok), 32'(v.x_qkok));
    checkField({s, " vk"}, vk, v.x_vk);
    checkField({s, " commit_valid"}, 32'(commit_valid), 32'(v.x_cv));
    checkField({s, " clear"}, 32'(clear), 32'(v.x_clr));
    if (chk_pay) begin
      checkField({s, " commit_tag"}, 32'(commit_tag), 32'(v.x_ctag));
      checkField({s, " commit_rd"}, 32'(commit_rd), 32'(v.x_crd));
      checkField({s, " commit_val"}, commit_val, v.x_cval);
      checkField({s, " clear_pc"}, clear_pc, v.x_clrpc);
    end
  endtask

  initial begin
    vec_t tbl[16];
    vec_t v;
    logic prev_rst;

    rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_rd = '0;
    qj_tag = '0; qk_tag = '0; cdb_valid = 1'b0; cdb_tag = '0;
    cdb_val = '0; cdb_mispredict = 1'b0; cdb_target = '0;

    //           rst rdy iv ird qj qk cv ctag cval      m tgt | alloc full qjok vj                      qkok vk                     cv ctag rd cval     clr pc
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0,        0, 0,  0, 0, 0,   0,                        0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[1]  = '{0, 1, 1, 5, 0, 0, 0, 0, 0,        0, 0,  0, 0, 0,   0,                        0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[2]  = '{0, 1, 1, 6, 0, 0, 0, 0, 0,        0, 0,  1, 0, 0,   0,                        0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[3]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0,        0, 0,  2, 0, 0,   0,                        0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[4]  = '{0, 1, 0, 0, 1, 0, 1, 1, 'h22,     0, 0,  2, 0, BYP, BYP ? 32'h22 : 32'h0,     0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[5]  = '{0, 1, 0, 0, 1, 0, 1, 0, 'h11,     0, 0,  2, 0, 1,   'h22,                     BYP, BYP ? 32'h11 : 32'h0,  0, 0, 0, 0,        0, 0};
    tbl[6]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0,        0, 0,  2, 0, 1,   'h22,                     1,   'h11,                  0, 0, 0, 0,        0, 0};
    tbl[7]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0,        0, 0,  2, 0, 1,   'h22,                     0,   0,                     1, 0, 5, 'h11,     0, 0};
    tbl[8]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0,        0, 0,  2, 0, 0,   0,                        0,   0,                     1, 1, 6, 'h22,     0, 0};
    tbl[9]  = '{0, 1, 1, 7, 0, 0, 0, 0, 0,        0, 0,  2, 0, 0,   0,                        0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[10] = '{0, 1, 0, 0, 2, 3, 1, 2, 'hABCD,   0, 0,  3, 0, BYP, BYP ? 32'hABCD : 32'h0,   0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[11] = '{0, 0, 0, 0, 2, 3, 0, 0, 0,        0, 0,  3, 0, 1,   'hABCD,                   0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[12] = '{0, 0, 1, 9, 2, 3, 0, 0, 0,        0, 0,  3, 0, 1,   'hABCD,                   0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[13] = '{0, 1, 0, 0, 2, 3, 0, 0, 0,        0, 0,  3, 0, 1,   'hABCD,                   0,   0,                     0, 0, 0, 0,        0, 0};
    tbl[14] = '{0, 1, 0, 0, 2, 3, 0, 0, 0,        0, 0,  3, 0, 0,   0,                        0,   0,                     1, 2, 7, 'hABCD,   0, 0};
    tbl[15] = '{0, 1, 0, 0, 2, 3, 0, 0, 0,        0, 0,  3, 0, 0,   0,                        0,   0,                     0, 0, 0, 0,        0, 0};

    prev_rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], tbl[i].x_cv || prev_rst, i);
      prev_rst = tbl[i].rst;
    end

    // Fill all 16 entries, refuse a 17th, then retire while refilling.
    v = idle(); v.rst = 1'b1; applyStimulus(v);
    for (int i = 0; i < 16; i++) begin
      v = idle(); v.iv = 1'b1; v.ird = 5'(i + 1);
      applyStimulus(v);
      checkField("fill alloc_tag", 32'(alloc_tag), 32'(i));
      checkField("fill rob_full", 32'(rob_full), 32'd0);
    end
    v = idle(); v.iv = 1'b1; v.ird = 5'd20; applyStimulus(v);
    checkField("full rob_full", 32'(rob_full), 32'd1);
    checkField("full alloc_tag", 32'(alloc_tag), 32'd0);
    v = idle(); v.cv = 1'b1; v.ctag = 4'd0; v.cval = 32'h100; applyStimulus(v);
    checkField("overissue alloc_tag", 32'(alloc_tag), 32'd0);
    checkField("overissue rob_full", 32'(rob_full), 32'd1);
    v = idle(); v.iv = 1'b1; v.ird = 5'd21; v.cv = 1'b1; v.ctag = 4'd1; v.cval = 32'h101; applyStimulus(v);
    checkField("fullcommit rob_full", 32'(rob_full), 32'd1);
    checkField("fullcommit commit_valid", 32'(commit_valid), 32'd0);
    v = idle(); v.iv = 1'b1; v.ird = 5'd22; applyStimulus(v);
    checkField("refused alloc_tag", 32'(alloc_tag), 32'd0);
    checkField("refused rob_full", 32'(rob_full), 32'd0);
    checkField("wrap commit_valid", 32'(commit_valid), 32'd1);
    checkField("wrap commit_tag", 32'(commit_tag), 32'd0);
    checkField("wrap commit_rd", 32'(commit_rd), 32'd1);
    checkField("wrap commit_val", commit_val, 32'h100);
    v = idle(); v.iv = 1'b1; v.ird = 5'd23; applyStimulus(v);
    checkField("issue+commit alloc_tag", 32'(alloc_tag), 32'd1);
    checkField("issue+commit rob_full", 32'(rob_full), 32'd0);
    checkField("issue+commit commit_tag", 32'(commit_tag), 32'd1);
    checkField("issue+commit commit_rd", 32'(commit_rd), 32'd2);
    checkField("issue+commit commit_val", commit_val, 32'h101);
    v = idle(); v.qj = 4'd0; v.qk = 4'd1; applyStimulus(v);
    checkField("refill rob_full", 32'(rob_full), 32'd1);
    checkField("refill alloc_tag", 32'(alloc_tag), 32'd2);
    checkField("refill commit_valid", 32'(commit_valid), 32'd0);
    checkField("reissued qj_ok", 32'(qj_ok), 32'd0);
    checkField("reissued qk_ok", 32'(qk_ok), 32'd0);

    // Mispredicted branch at tag 1 retires and squashes tags 2 and 3.
    v = idle(); v.rst = 1'b1; applyStimulus(v);
    for (int i = 0; i < 4; i++) begin
      v = idle(); v.iv = 1'b1; v.ird = 5'(i + 1); applyStimulus(v);
    end
    v = idle(); v.cv = 1'b1; v.ctag = 4'd1; v.cval = 32'h77; v.cmisp = 1'b1; v.ctgt = 32'h1000;
    applyStimulus(v);
    v = idle(); v.cv = 1'b1; v.ctag = 4'd0; v.cval = 32'h66; applyStimulus(v);
    v = idle(); applyStimulus(v);
    checkField("misp pre commit_valid", 32'(commit_valid), 32'd0);
    v = idle(); v.iv = 1'b1; v.ird = 5'd9; applyStimulus(v);
    checkField("misp c0 commit_valid", 32'(commit_valid), 32'd1);
    checkField("misp c0 commit_tag", 32'(commit_tag), 32'd0);
    checkField("misp c0 commit_rd", 32'(commit_rd), 32'd1);
    checkField("misp c0 commit_val", commit_val, 32'h66);
    checkField("misp c0 clear", 32'(clear), 32'd0);
    v = idle(); v.cv = 1'b1; v.ctag = 4'd2; v.cval = 32'h99; v.qj = 4'd2; applyStimulus(v);
    checkField("misp c1 commit_valid", 32'(commit_valid), 32'd1);
    checkField("misp c1 commit_tag", 32'(commit_tag), 32'd1);
    checkField("misp c1 commit_rd", 32'(commit_rd), 32'd2);
    checkField("misp c1 commit_val", commit_val, 32'h77);
    checkField("misp c1 clear", 32'(clear), 32'd1);
    checkField("misp c1 clear_pc", clear_pc, 32'h1000);
    checkField("misp c1 alloc_tag", 32'(alloc_tag), 32'd0);
    checkField("misp c1 rob_full", 32'(rob_full), 32'd0);
    checkField("misp c1 qj_ok", 32'(qj_ok), 32'd0);
    checkField("misp c1 vj", vj, 32'd0);
    v = idle(); v.qj = 4'd2; applyStimulus(v);
    checkField("misp post commit_valid", 32'(commit_valid), 32'd0);
    checkField("misp post clear", 32'(clear), 32'd0);
    checkField("misp post alloc_tag", 32'(alloc_tag), 32'd0);
    checkField("misp post qj_ok", 32'(qj_ok), 32'd0);
    v = idle(); v.iv = 1'b1; v.ird = 5'd10; applyStimulus(v);
    checkField("squashed commit_valid", 32'(commit_valid), 32'd0);
    v = idle(); v.cv = 1'b1; v.ctag = 4'd0; v.cval = 32'h1; applyStimulus(v);
    checkField("after flush alloc_tag", 32'(alloc_tag), 32'd1);
    checkField("after flush commit_valid", 32'(commit_valid), 32'd0);

    // Reset lands on the edge where tag 0 would otherwise retire.
    v = idle(); v.rst = 1'b1; applyStimulus(v);
    checkField("pre reset commit_valid", 32'(commit_valid), 32'd0);
    v = idle(); v.qj = 4'd0; applyStimulus(v);
    checkField("midreset commit_valid", 32'(commit_valid), 32'd0);
    checkField("midreset alloc_tag", 32'(alloc_tag), 32'd0);
    checkField("midreset qj_ok", 32'(qj_ok), 32'd0);
    checkField("midreset rob_full", 32'(rob_full), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompares);
    $finish;
  end

endmodule
